pulse_sequencer: RTL and testbench
==================================

# pulse_sequencer

Controller that shares one periodic single-cycle pulse datapath between `N_REQ` requesters. Each requester asks for a burst of `C` pulses spaced `P` cycles apart. The block arbitrates, latches the winner's period and count, and sequences the burst with a grant/done handshake. It sits between the requester logic and the shared pulse output, which is the periodic "count and fire on zero" behaviour generalised to programmable period and length.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `PERIOD_W`, 4, width of each per-requester period field
- `COUNT_W`, 4, width of each per-requester pulse-count field

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  N_REQ  level request, one bit per requester
- `period`  in  N_REQ*PERIOD_W  packed periods; requester i uses bits [i*PERIOD_W +: PERIOD_W]
- `count`  in  N_REQ*COUNT_W  packed pulse counts; requester i uses bits [i*COUNT_W +: COUNT_W]
- `grant`  out  N_REQ  one-hot owner of the current burst
- `busy`  out  1  high while a burst is granted
- `pulse`  out  1  shared single-cycle pulse output
- `done`  out  N_REQ  one-cycle completion strobe to the owner

All outputs are registered.

## Operation
- FSM states:
  - IDLE: `grant`, `busy`, `pulse` and `done` all 0. If `req` != 0 at an edge, pick a winner, latch its `period`/`count`, and move on:
    - to RUN if count != 0;
    - to DONE if count == 0.
  - RUN: `grant` = winner, `busy` = 1.
    - Internal phase counter `ph` runs 0..Peff-1, where Peff = (P == 0) ? 1 : P.
    - `pulse` = 1 exactly when `ph` == 0.
    - A remaining-pulse counter decrements on each pulse.
    - Move to DONE when the last pulse's period has elapsed, i.e. after C*Peff RUN cycles.
  - DONE: one cycle. `grant` = winner, `busy` = 1, `pulse` = 0, `done[winner]` = 1. Then IDLE.
- Latched `period`/`count` are fixed for the whole burst. Input changes after the grant are ignored.
- `req` is sampled only in IDLE. Changes to `req` during RUN/DONE have no effect; a burst always completes.
- Handshake: a requester holds `req` until it sees its `done` bit, then deasserts on the following edge. A `req` still high in the IDLE cycle after DONE is treated as a new request.
- Arithmetic: `ph` is PERIOD_W bits and wraps Peff-1 -> 0. The remaining counter is COUNT_W bits and never underflows (RUN is entered only with count >= 1).
- Arbitration: see Configuration. The winner is always a bit set in `req` at the sampling edge.
- `rst` (any state, including mid-burst): next cycle is IDLE with all outputs 0, no `done` issued, arbitration pointer = 0.

## Timing
- `req` sampled at edge k (IDLE) -> `grant`/`busy` high from cycle k+1.
- First `pulse` in cycle k+1.
- Pulse i (0-based) in cycle k+1+i*Peff.
- `done` in cycle k+1+C*Peff. `busy` is low in cycle k+2+C*Peff (IDLE).
- Earliest next grant is visible in cycle k+3+C*Peff, so there is a one-cycle IDLE gap between bursts.
- C == 0: `grant`, `busy` and `done` all high in cycle k+1, no pulse, IDLE in cycle k+2.
- Peff == 1: pulse every cycle, C consecutive pulses.

## Configuration
- `PULSE_SEQ_RR_EN` defined: round-robin arbitration.
  - A pointer holds the index after the last winner (reset 0).
  - The winner is the first set `req` bit at or after the pointer, wrapping.
  - The pointer updates when the grant is issued.
- `PULSE_SEQ_RR_EN` undefined: fixed priority, lowest set index wins. No pointer register.

## Test plan
- Single burst: after reset, `req`=0001, P=4, C=3 sampled at edge 0 -> `grant`=0001 and `busy` in cycles 1..13; `pulse` in cycles 1, 5 and 9 only; `done`=0001 in cycle 13; `busy`=0 in cycle 14.
- Zero count: `req`=0100, C=0, P=5 -> cycle 1: `grant`=0100, `busy`=1, `done`=0100, `pulse`=0; cycle 2: all outputs 0.
- Zero period: `req`=0010, P=0, C=3 -> `pulse` in cycles 1, 2 and 3; `done`=0010 in cycle 4.
- Arbitration, with `req`=1111 held and each requester re-asserting after its `done` (P=1, C=1; each burst is 3 cycles incl. the IDLE gap):
  - with `PULSE_SEQ_RR_EN`: grant order 0001, 0010, 0100, 1000, 0001;
  - without it: grant order 0001, 0001, 0001.
- Reset mid-burst: P=4, C=3; assert `rst` during cycle 6 -> cycle 7 has all outputs 0 and no `done` ever appears. With `req`=1000 held, the next grant is 1000 at cycle 9 (reset released after cycle 7).
- Config change mid-burst: P=2, C=2 granted; change `period` to 7 and `count` to 9 during RUN -> pulses still in cycles 1 and 3, `done` in cycle 5.

Source files
------------

// File: rtl/pulse_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sequencer_if
// Brief    : Request/grant bundle between requesters and the pulse sequencer.
// Revision : 1.0
// ============================================================================
interface pulse_sequencer_if #(
  parameter int N_REQ    = 4,
  parameter int PERIOD_W = 4,
  parameter int COUNT_W  = 4
);
  logic [N_REQ-1:0]          req;
  logic [N_REQ*PERIOD_W-1:0] period;
  logic [N_REQ*COUNT_W-1:0]  count;
  logic [N_REQ-1:0]          grant;
  logic                      busy;
  logic                      pulse;
  logic [N_REQ-1:0]          done;

  modport master (
    output req, period, count,
    input  grant, busy, pulse, done
  );

  modport slave (
    input  req, period, count,
    output grant, busy, pulse, done
  );
endinterface
`default_nettype wire

// File: rtl/pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sequencer
// Brief    : Shares one periodic burst-pulse generator between N_REQ requesters.
//            Define PULSE_SEQ_RR_EN for round-robin arbitration (default: fixed
//            priority, lowest index wins).
// Revision : 1.0
// ============================================================================
module pulse_sequencer #(
  parameter int N_REQ    = 4,
  parameter int PERIOD_W = 4,
  parameter int COUNT_W  = 4
) (
  input wire logic         clk,
  input wire logic         rst,
  pulse_sequencer_if.slave bus
);

  localparam int C_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [N_REQ-1:0]    r_done;
  logic                r_busy;
  logic                r_pulse;
  logic [PERIOD_W-1:0] r_plast;
  logic [PERIOD_W-1:0] r_ph;
  logic [COUNT_W-1:0]  r_rem;

  logic [C_PTR_W-1:0]  w_win_idx;
  logic [N_REQ-1:0]    w_win_oh;
  logic [PERIOD_W-1:0] w_win_per;
  logic [PERIOD_W-1:0] w_win_plast;
  logic [COUNT_W-1:0]  w_win_cnt;
  logic [PERIOD_W-1:0] w_ph_nxt;

`ifdef PULSE_SEQ_RR_EN
  logic [C_PTR_W-1:0]  r_ptr;
  logic [C_PTR_W-1:0]  w_cand;

  // Scan offsets from the far end down so the nearest set bit at/after r_ptr wins.
  always_comb begin
    w_win_idx = r_ptr;
    w_cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = C_PTR_W'((int'(r_ptr) + i) % N_REQ);
      if (bus.req[w_cand]) begin
        w_win_idx = w_cand;
      end
    end
  end
`else
  always_comb begin
    w_win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_win_idx = C_PTR_W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_win_per = '0;
    w_win_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_idx == C_PTR_W'(i)) begin
        w_win_per = bus.period[i*PERIOD_W +: PERIOD_W];
        w_win_cnt = bus.count[i*COUNT_W +: COUNT_W];
      end
    end
  end

  assign w_win_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
  // A zero period behaves as period 1, so the last phase index is 0 in both cases.
  assign w_win_plast = (w_win_per == '0) ? '0 : w_win_per - 1'b1;
  assign w_ph_nxt    = (r_ph == r_plast) ? '0 : r_ph + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_pulse <= 1'b0;
      r_done  <= '0;
      r_plast <= '0;
      r_ph    <= '0;
      r_rem   <= '0;
`ifdef PULSE_SEQ_RR_EN
      r_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pulse <= 1'b0;
          r_done  <= '0;
          if (bus.req != '0) begin
            r_grant <= w_win_oh;
            r_busy  <= 1'b1;
            r_plast <= w_win_plast;
            r_ph    <= '0;
`ifdef PULSE_SEQ_RR_EN
            r_ptr   <= (w_win_idx == C_PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
`endif
            if (w_win_cnt == '0) begin
              r_state <= S_DONE;
              r_done  <= w_win_oh;
              r_rem   <= '0;
            end else begin
              r_state <= S_RUN;
              r_pulse <= 1'b1;
              r_rem   <= w_win_cnt - 1'b1;
            end
          end
        end

        // r_rem counts pulses still to fire after the one already issued.
        S_RUN: begin
          r_ph <= w_ph_nxt;
          if (w_ph_nxt == '0) begin
            if (r_rem == '0) begin
              r_state <= S_DONE;
              r_pulse <= 1'b0;
              r_done  <= r_grant;
            end else begin
              r_pulse <= 1'b1;
              r_rem   <= r_rem - 1'b1;
            end
          end else begin
            r_pulse <= 1'b0;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_pulse <= 1'b0;
          r_done  <= '0;
        end

        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_pulse <= 1'b0;
          r_done  <= '0;
        end
      endcase
    end
  end

  assign bus.grant = r_grant;
  assign bus.busy  = r_busy;
  assign bus.pulse = r_pulse;
  assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// Bench for pulse_sequencer: table-driven bursts plus hand-written corner sequences,
// checked cycle by cycle against a queue of expected outputs.
module tb_pulse_sequencer;
  localparam int N  = 4;
  localparam int PW = 4;
  localparam int CW = 4;

  bit   clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  pulse_sequencer_if #(.N_REQ(N), .PERIOD_W(PW), .COUNT_W(CW)) bus ();

  pulse_sequencer #(.N_REQ(N), .PERIOD_W(PW), .COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    int           tag;
    logic [N-1:0] grant;
    logic         busy;
    logic         pulse;
    logic [N-1:0] done;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    logic [3:0]   p;
    logic [3:0]   c;
    logic [N-1:0] g_fp;
    logic [N-1:0] g_rr;
  } vec_t;

  exp_t sb[$];
  vec_t vt[9];

  always @(negedge clk) begin : chk
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cyc || bus.grant !== e.grant || bus.busy !== e.busy ||
          bus.pulse !== e.pulse || bus.done !== e.done) begin
        n_fail++;
        $display("FAIL tag=%0d cyc=%0d (exp cyc %0d) grant/busy/pulse/done got %b/%b/%b/%b want %b/%b/%b/%b",
                 e.tag, cyc, e.cyc, bus.grant, bus.busy, bus.pulse, bus.done,
                 e.grant, e.busy, e.pulse, e.done);
      end
    end
  end

  task automatic push_one(input int c, input int tag, input logic [N-1:0] g,
                          input logic b, input logic p, input logic [N-1:0] d);
    exp_t e;
    e.cyc = c; e.tag = tag; e.grant = g; e.busy = b; e.pulse = p; e.done = d;
    sb.push_back(e);
  endtask

  // Burst sampled at edge k: pulses every Peff cycles from k+1, done at k+1+C*Peff, idle after.
  task automatic push_burst(input int k, input logic [N-1:0] g, input int p,
                            input int c, input int tag);
    int peff;
    int d;
    peff = (p == 0) ? 1 : p;
    d    = c * peff;
    for (int t = 1; t <= d; t++) begin
      push_one(k + t, tag, g, 1'b1, ((t - 1) % peff) == 0, '0);
    end
    push_one(k + 1 + d, tag, g, 1'b1, 1'b0, g);
    push_one(k + 2 + d, tag, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_drain(input int tag);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tag=%0d drain timeout: %0d expected entries left, want 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input int n, input int tag);
    int c;
    c = cyc;
    rst = 1'b1;
    bus.req = '0;
    for (int i = 1; i <= n + 1; i++) push_one(c + i, tag, '0, 1'b0, 1'b0, '0);
    wait_cyc(c + n);
    rst = 1'b0;
    wait_drain(tag);
  endtask

  // Winner slot gets (p,c); every other slot gets different values the DUT must ignore.
  task automatic load_slots(input int w, input logic [3:0] p, input logic [3:0] c);
    for (int i = 0; i < N; i++) begin
      bus.period[i*PW +: PW] = (i == w) ? p : p + 4'd7;
      bus.count[i*CW +: CW]  = (i == w) ? c : c + 4'd5;
    end
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    logic [N-1:0] g;
    int           w;
    int           k;
`ifdef PULSE_SEQ_RR_EN
    g = v.g_rr;
`else
    g = v.g_fp;
`endif
    w = 0;
    for (int i = 0; i < N; i++) if (g[i]) w = i;
    load_slots(w, v.p, v.c);
    bus.req = v.req;
    k = cyc;
    push_burst(k, g, int'(v.p), int'(v.c), tag);
    @(negedge clk);
    bus.req = '0;
    wait_drain(tag);
  endtask

  initial begin
    int k;
    //          req      P      C      fixed    round-robin
    vt[0] = '{4'b0001, 4'd4,  4'd3, 4'b0001, 4'b0001};
    vt[1] = '{4'b0100, 4'd5,  4'd0, 4'b0100, 4'b0100};
    vt[2] = '{4'b0010, 4'd0,  4'd3, 4'b0010, 4'b0010};
    vt[3] = '{4'b1010, 4'd1,  4'd2, 4'b0010, 4'b1000};
    vt[4] = '{4'b1100, 4'd2,  4'd2, 4'b0100, 4'b0100};
    vt[5] = '{4'b0011, 4'd3,  4'd1, 4'b0001, 4'b0001};
    vt[6] = '{4'b1001, 4'd1,  4'd4, 4'b0001, 4'b1000};
    vt[7] = '{4'b1111, 4'd15, 4'd1, 4'b0001, 4'b0001};
    vt[8] = '{4'b0110, 4'd0,  4'd0, 4'b0010, 4'b0010};

    rst        = 1'b1;
    bus.req    = '0;
    bus.period = '0;
    bus.count  = '0;
    do_reset(3, 100);

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Inputs rewritten mid-burst must not disturb the latched period/count.
    load_slots(0, 4'd2, 4'd2);
    bus.req = 4'b0001;
    k = cyc;
    push_burst(k, 4'b0001, 2, 2, 20);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    bus.period = {N{4'd7}};
    bus.count  = {N{4'd9}};
    wait_drain(20);

    // Reset during RUN: no done, then the held request is re-granted.
    load_slots(3, 4'd4, 4'd3);
    bus.req = 4'b1000;
    k = cyc;
    for (int t = 1; t <= 6; t++) push_one(k + t, 30, 4'b1000, 1'b1, ((t - 1) % 4) == 0, '0);
    wait_cyc(k + 6);
    rst = 1'b1;
    push_one(k + 7, 30, '0, 1'b0, 1'b0, '0);
    push_one(k + 8, 30, '0, 1'b0, 1'b0, '0);
    wait_cyc(k + 8);
    rst = 1'b0;
    push_burst(k + 8, 4'b1000, 4, 3, 31);
    wait_cyc(k + 9);
    bus.req = '0;
    wait_drain(31);

    // All requesters held high: back-to-back 3-cycle bursts.
    do_reset(2, 101);
    bus.period = {N{4'd1}};
    bus.count  = {N{4'd1}};
    bus.req    = 4'b1111;
    k = cyc;
    for (int b = 0; b < 5; b++) begin
`ifdef PULSE_SEQ_RR_EN
      push_burst(k + 3*b, 4'b0001 << (b % 4), 1, 1, 40 + b);
`else
      push_burst(k + 3*b, 4'b0001, 1, 1, 40 + b);
`endif
    end
    push_one(k + 16, 45, '0, 1'b0, 1'b0, '0);
    wait_cyc(k + 15);
    bus.req = '0;
    wait_drain(45);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
